// File: rtl/router_pkg.sv
// Shared definitions for the bufferless mesh router: direction codes, flit
// field positions and the dimension-ordered (column first) route function.
package router_pkg;

  localparam int FLIT_W  = 10;
  localparam int ADR_W   = 6;
  localparam int GBO_BIT = 9;
  localparam int DIR_MSB = 8;
  localparam int DIR_LSB = 6;
  localparam int ADR_MSB = 5;
  localparam int ADR_LSB = 0;

  typedef enum logic [2:0] {
    EAST  = 3'b000,
    WEST  = 3'b001,
    NORTH = 3'b010,
    SOUTH = 3'b011,
    LOCAL = 3'b100
  } dir_e;

  // Columns are resolved before rows; an address matching this node loops back.
  function automatic dir_e route(input logic [ADR_W-1:0] addr,
                                 input logic [2:0]       row_id,
                                 input logic [2:0]       col_id);
    logic [2:0] row;
    logic [2:0] col;
    row = addr[5:3];
    col = addr[2:0];
    if (col > col_id)      return EAST;
    else if (col < col_id) return WEST;
    else if (row > row_id) return NORTH;
    else if (row < row_id) return SOUTH;
    else                   return LOCAL;
  endfunction

endpackage

// File: rtl/injector_if.sv
// Injector bundle: core-side address handshake plus the four channel flits in
// and out, and the loopback/starvation status toward the router.
interface injector_if;
  import router_pkg::*;

  logic [FLIT_W-1:0] nad;
  logic [FLIT_W-1:0] sad;
  logic [FLIT_W-1:0] ead;
  logic [FLIT_W-1:0] wad;
  logic              inj_valid;
  logic [ADR_W-1:0]  inj_addr;
  logic              inj_ready;
  logic [FLIT_W-1:0] nout;
  logic [FLIT_W-1:0] sout;
  logic [FLIT_W-1:0] eout;
  logic [FLIT_W-1:0] wout;
  logic [FLIT_W-1:0] lo_flit;
  logic              lo_valid;
  logic              inj_starve;

  modport master (
    output nad, sad, ead, wad, inj_valid, inj_addr,
    input  inj_ready, nout, sout, eout, wout, lo_flit, lo_valid, inj_starve
  );

  modport slave (
    input  nad, sad, ead, wad, inj_valid, inj_addr,
    output inj_ready, nout, sout, eout, wout, lo_flit, lo_valid, inj_starve
  );

endinterface

// File: rtl/inj_fifo.sv
// Synchronous FIFO holding pending destination addresses; pushes are refused
// while full even if a pop happens in the same cycle.
module inj_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/injector.sv
// Local-port injection stage: routes the FIFO head into the first blank
// channel (N > S > E > W) or the loopback port, with one registered stage out.
module injector
  import router_pkg::*;
#(
  parameter logic [2:0] ROW_ID       = 3'd4,
  parameter logic [2:0] COL_ID       = 3'd4,
  parameter int         DEPTH        = 4,
  parameter int         STARVE_LIMIT = 8
) (
  input logic       clk,
  input logic       rst_n,
  injector_if.slave bus
);

  localparam int              CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [ADR_W-1:0]  head_addr;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              head_local;
  dir_e              head_dir;
  logic [FLIT_W-1:0] head_flit;
  logic [FLIT_W-1:0] chan_in   [4];
  logic [FLIT_W-1:0] chan_next [4];
  logic              any_blank;
  logic [1:0]        blank_idx;
  logic [CNT_W-1:0]  starve_cnt;
  logic [CNT_W-1:0]  starve_next;

  assign bus.inj_ready = !fifo_full;

  inj_fifo #(.DEPTH(DEPTH), .WIDTH(ADR_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.inj_valid),
    .pop   (pop),
    .din   (bus.inj_addr),
    .dout  (head_addr),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign chan_in[0] = bus.nad;
  assign chan_in[1] = bus.sad;
  assign chan_in[2] = bus.ead;
  assign chan_in[3] = bus.wad;

  assign head_dir   = route(head_addr, ROW_ID, COL_ID);
  assign head_local = (head_dir == LOCAL);

  // NOTE: every output gets a default before any conditional update, so no latch is inferred.
  always_comb begin
    head_flit                  = '0;
    head_flit[GBO_BIT]         = 1'b1;
    head_flit[DIR_MSB:DIR_LSB] = head_dir;
    head_flit[ADR_MSB:ADR_LSB] = head_addr;

    // Scan from lowest priority upward so the last hit is the highest-priority blank.
    any_blank = 1'b0;
    blank_idx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (!chan_in[i][GBO_BIT]) begin
        any_blank = 1'b1;
        blank_idx = 2'(i);
      end
    end

    pop = !fifo_empty && (head_local || any_blank);

    for (int i = 0; i < 4; i++) chan_next[i] = chan_in[i];
    if (pop && !head_local) chan_next[blank_idx] = head_flit;

    starve_next = starve_cnt;
    if (pop)
      starve_next = '0;
    else if (!fifo_empty && !any_blank && starve_cnt != STARVE_MAX)
      starve_next = starve_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.nout       <= '0;
      bus.sout       <= '0;
      bus.eout       <= '0;
      bus.wout       <= '0;
      bus.lo_flit    <= '0;
      bus.lo_valid   <= 1'b0;
      bus.inj_starve <= 1'b0;
      starve_cnt     <= '0;
    end else begin
      bus.nout       <= chan_next[0];
      bus.sout       <= chan_next[1];
      bus.eout       <= chan_next[2];
      bus.wout       <= chan_next[3];
      bus.lo_valid   <= pop && head_local;
      if (pop && head_local) bus.lo_flit <= head_flit;
      bus.inj_starve <= (starve_next == STARVE_MAX);
      starve_cnt     <= starve_next;
    end
  end

endmodule

// File: tb/tb_injector.sv
// Scoreboard bench for injector: a queue-based reference model predicts each
// registered output cycle; a negedge monitor compares the DUT against it.
module tb_injector;

  localparam logic [9:0] B = 10'h000;
  localparam logic [9:0] O = 10'h3FF;

  typedef struct {
    logic [9:0] n, s, e, w, lo_flit;
    logic       lo_valid, starve, ready;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  exp_t exp_q[$];
  int   mq[$];
  int   scnt;

  injector_if bus();

  injector #(.ROW_ID(3'd4), .COL_ID(3'd4), .DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  // Dimension-ordered route of this node at (4,4): 0=E 1=W 2=N 3=S 4=local.
  function automatic int model_dir(input int a);
    int r, c;
    r = a / 8;
    c = a % 8;
    if (c > 4) return 0;
    if (c < 4) return 1;
    if (r > 4) return 2;
    if (r < 4) return 3;
    return 4;
  endfunction

  // Reference model: one prediction per clock edge out of reset.
  exp_t       m_e;
  logic [9:0] m_ch [4];
  int         m_blank, m_dir;
  bit         m_pop, m_push;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      exp_q.delete();
      scnt = 0;
    end else begin
      m_ch[0] = bus.nad; m_ch[1] = bus.sad; m_ch[2] = bus.ead; m_ch[3] = bus.wad;
      m_blank = -1;
      for (int i = 0; i < 4; i++) if (m_blank < 0 && !m_ch[i][9]) m_blank = i;
      m_push = bus.inj_valid && (mq.size() < 4);
      m_pop = 0;
      m_e.lo_valid = 0;
      m_e.lo_flit  = '0;
      if (mq.size() > 0) begin
        m_dir = model_dir(mq[0]);
        if (m_dir == 4) begin
          m_pop = 1;
          m_e.lo_valid = 1;
          m_e.lo_flit  = {1'b1, 3'(m_dir), 6'(mq[0])};
        end else if (m_blank >= 0) begin
          m_pop = 1;
          m_ch[m_blank] = {1'b1, 3'(m_dir), 6'(mq[0])};
        end
      end
      if (m_pop) begin
        void'(mq.pop_front());
        scnt = 0;
      end else if (mq.size() > 0 && m_blank < 0 && scnt < 8) begin
        scnt++;
      end
      if (m_push) mq.push_back(int'(bus.inj_addr));
      m_e.n = m_ch[0]; m_e.s = m_ch[1]; m_e.e = m_ch[2]; m_e.w = m_ch[3];
      m_e.starve = (scnt == 8);
      m_e.ready  = (mq.size() < 4);
      exp_q.push_back(m_e);
    end
  end

  // Monitor: compare at the falling edge, away from the active edge.
  exp_t got;
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_nout",     bus.nout,       B);
      check("rst_sout",     bus.sout,       B);
      check("rst_eout",     bus.eout,       B);
      check("rst_wout",     bus.wout,       B);
      check("rst_lo_flit",  bus.lo_flit,    B);
      check("rst_lo_valid", bus.lo_valid,   10'd0);
      check("rst_starve",   bus.inj_starve, 10'd0);
      check("rst_ready",    bus.inj_ready,  10'd1);
    end else if (exp_q.size() > 0) begin
      got = exp_q.pop_front();
      check("nout",     bus.nout,       got.n);
      check("sout",     bus.sout,       got.s);
      check("eout",     bus.eout,       got.e);
      check("wout",     bus.wout,       got.w);
      check("lo_valid", bus.lo_valid,   10'(got.lo_valid));
      check("starve",   bus.inj_starve, 10'(got.starve));
      check("ready",    bus.inj_ready,  10'(got.ready));
      if (got.lo_valid) check("lo_flit", bus.lo_flit, got.lo_flit);
    end
  end

  task automatic step(input logic [9:0] n, s, e, w, input logic v, input logic [5:0] a);
    bus.nad = n; bus.sad = s; bus.ead = e; bus.wad = w;
    bus.inj_valid = v;
    bus.inj_addr  = a;
    @(posedge clk);
    #2;
  endtask

  task automatic rand_step(input int occ_pct);
    logic [9:0] ch [4];
    logic [5:0] a;
    for (int i = 0; i < 4; i++) begin
      ch[i]    = 10'($urandom);
      ch[i][9] = ($urandom_range(99) < occ_pct);
    end
    a = ($urandom_range(7) == 0) ? 6'o44 : 6'($urandom);
    step(ch[0], ch[1], ch[2], ch[3], 1'($urandom), a);
  endtask

  initial begin
    // Reset held with random inputs.
    repeat (3) rand_step(50);
    rst_n = 1'b1;

    // All channels blank: east-bound flit lands on nout two edges after push.
    step(B, B, B, B, 1'b1, 6'o46);
    repeat (3) step(B, B, B, B, 1'b0, 6'o00);

    // Only west blank: south-bound flit lands on wout.
    step(O, O, O, B, 1'b1, 6'o14);
    repeat (3) step(O, O, O, B, 1'b0, 6'o00);

    // All occupied: starve saturates, then a blank south channel drains it.
    step(O, O, O, O, 1'b1, 6'o00);
    repeat (10) step(O, O, O, O, 1'b0, 6'o00);
    step(O, B, O, O, 1'b0, 6'o00);
    repeat (2) step(O, O, O, O, 1'b0, 6'o00);

    // Fill the FIFO, attempt a fifth push, then drain through wout in order.
    step(O, O, O, O, 1'b1, 6'o01);
    step(O, O, O, O, 1'b1, 6'o72);
    step(O, O, O, O, 1'b1, 6'o47);
    step(O, O, O, O, 1'b1, 6'o14);
    check("full_ready", bus.inj_ready, 10'd0);
    step(O, O, O, O, 1'b1, 6'o33);
    repeat (7) step(O, O, O, B, 1'b0, 6'o00);

    // Self-addressed: loopback regardless of channel occupancy.
    step(O, O, O, O, 1'b1, 6'o44);
    repeat (2) step(O, O, O, O, 1'b0, 6'o00);
    step(B, B, B, B, 1'b1, 6'o44);
    repeat (2) step(B, B, B, B, 1'b0, 6'o00);

    // Reset with three entries queued: nothing queued survives release.
    step(O, O, O, O, 1'b1, 6'o05);
    step(O, O, O, O, 1'b1, 6'o22);
    step(O, O, O, O, 1'b1, 6'o63);
    step(O, O, O, O, 1'b0, 6'o00);
    rst_n = 1'b0;
    #1;
    check("midrst_nout",  bus.nout,      B);
    check("midrst_ready", bus.inj_ready, 10'd1);
    repeat (2) rand_step(50);
    rst_n = 1'b1;
    repeat (5) step(B, B, B, B, 1'b0, 6'o00);

    // Randomized traffic at mixed channel loads.
    repeat (200) rand_step(80);
    repeat (200) rand_step(40);
    repeat (100) rand_step(97);
    repeat (6) step(B, B, B, B, 1'b0, 6'o00);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
